// File: rtl/stim_feeder_pkg.sv
// Shared constants and state encoding for the stimulus feeder and its skid register.
package stim_feeder_pkg;

    localparam int unsigned ADDR_WL_DEF = 9;
    localparam int unsigned DATA_WL_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_CLEAR  = 3'b001,
        ST_FEED   = 3'b011,
        ST_DRAIN  = 3'b010,
        ST_FINISH = 3'b110
    } feed_state_e;

    function automatic logic is_streaming(feed_state_e s);
        return (s == ST_FEED) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/stim_feeder_skid.sv
// One-entry skid register catching a BRAM word that arrives while the FIFO is full.
module stim_skid
    import stim_feeder_pkg::*;
#(
    parameter int DataWL = DATA_WL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              unload,
    input  logic [DataWL-1:0] din,
    output logic              valid,
    output logic [DataWL-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stim_feeder.sv
// Streams one BRAM pass of stimulus words into the DUT-bound FIFO, with a skid for FIFO back-pressure.
// Build option: STIM_FEEDER_LOOP_EN keeps feeding from address 0 while start stays high.
//
// state  | meaning
// IDLE   | waiting for start with the MMCM locked
// CLEAR  | one-cycle FIFO flush, address reset to 0
// FEED   | issuing BRAM reads and forwarding words to the FIFO
// DRAIN  | last read issued, flushing the pending/skid word
// FINISH | one-cycle done pulse
module stim_feeder
    import stim_feeder_pkg::*;
#(
    parameter int AddrWL = ADDR_WL_DEF,
    parameter int DataWL = DATA_WL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mmcm_lock,
    output logic              bram_read_en,
    output logic [AddrWL-1:0] bram_address_read,
    input  logic [DataWL-1:0] bram_data_in,
    input  logic              fifo_full,
    output logic              fifo_write_en,
    output logic [DataWL-1:0] fifo_data_out,
    output logic              fifo_clear,
    output logic              busy,
    output logic              done
);

    localparam logic [AddrWL-1:0] ADDR_ONE = {{(AddrWL-1){1'b0}}, 1'b1};

    feed_state_e       state, state_nxt;
    logic [AddrWL-1:0] addr;
    logic              rd_pending;
    logic              rd_issue;
    logic              abort;
    logic              skid_valid;
    logic [DataWL-1:0] skid_data;
    logic [DataWL-1:0] wr_data;
    logic [DataWL-1:0] data_hold;

    // Losing lock mid-pass kills both strobes in the same cycle so nothing leaks out.
    assign abort         = is_streaming(state) && !mmcm_lock;
    assign rd_issue      = (state == ST_FEED) && mmcm_lock && !fifo_full && !skid_valid && !rst;
    assign fifo_write_en = !rst && !abort && (rd_pending || skid_valid) && !fifo_full;
    assign wr_data       = skid_valid ? skid_data : bram_data_in;
    assign fifo_data_out = fifo_write_en ? wr_data : data_hold;

    assign bram_read_en      = rd_issue;
    assign bram_address_read = addr;

    stim_skid #(.DataWL(DataWL)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .clear  (abort),
        .load   (rd_pending && fifo_full),
        .unload (skid_valid && !fifo_full),
        .din    (bram_data_in),
        .valid  (skid_valid),
        .data   (skid_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr       <= '0;
            rd_pending <= 1'b0;
            data_hold  <= '0;
        end else begin
            state      <= state_nxt;
            rd_pending <= rd_issue && !abort;
            if (state == ST_CLEAR) begin
                addr <= '0;
            end else if (rd_issue) begin
                addr <= addr + ADDR_ONE;
            end
            if (fifo_write_en) begin
                data_hold <= wr_data;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        fifo_clear = 1'b0;
        done       = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start && mmcm_lock) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                fifo_clear = 1'b1;
                state_nxt  = ST_FEED;
            end
            ST_FEED: begin
                if (!mmcm_lock) begin
                    state_nxt = ST_IDLE;
                end else if (rd_issue && (addr == '1)) begin
`ifdef STIM_FEEDER_LOOP_EN
                    if (!start) state_nxt = ST_DRAIN;
`else
                    state_nxt = ST_DRAIN;
`endif
                end
            end
            ST_DRAIN: begin
                if (!mmcm_lock) begin
                    state_nxt = ST_IDLE;
                end else if (!rd_pending && !skid_valid) begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (rst) begin
            fifo_clear = 1'b0;
            done       = 1'b0;
            busy       = 1'b0;
        end
    end

endmodule

// File: tb/tb_stim_feeder.sv
// Scoreboard bench for stim_feeder: stimulus queues expected FIFO words, a negedge monitor checks them.
module tb_stim_feeder;

    localparam int AW = 3;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst, start, mmcm_lock, fifo_full;
    logic          bram_read_en, fifo_write_en, fifo_clear, busy, done;
    logic [AW-1:0] bram_address_read;
    logic [DW-1:0] bram_data_in, fifo_data_out;
    logic [DW-1:0] bram_q;

    stim_feeder #(.AddrWL(AW), .DataWL(DW)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .mmcm_lock         (mmcm_lock),
        .bram_read_en      (bram_read_en),
        .bram_address_read (bram_address_read),
        .bram_data_in      (bram_data_in),
        .fifo_full         (fifo_full),
        .fifo_write_en     (fifo_write_en),
        .fifo_data_out     (fifo_data_out),
        .fifo_clear        (fifo_clear),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    // BRAM model: content[i] = 0x100 + i, one-cycle read latency
    initial bram_q = '0;
    always @(posedge clk) if (bram_read_en) bram_q <= 16'h0100 | {13'd0, bram_address_read};
    assign bram_data_in = bram_q;

    int checks = 0, failures = 0;
    int cyc = 0, n_wr = 0, n_clear = 0, n_done = 0, n_rd_full = 0;
    int last_wr_cyc = 0, last_done_cyc = 0, last_clear_cyc = 0, first_wr_cyc = 0, wr_since_clear = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_out = '0;
    logic [DW-1:0] exp_w;
    logic          rst_q = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (fifo_clear) begin
            n_clear++;
            last_clear_cyc = cyc;
            wr_since_clear = 0;
        end
        if (fifo_write_en) begin
            n_wr++;
            last_wr_cyc = cyc;
            if (wr_since_clear == 0) first_wr_cyc = cyc;
            wr_since_clear++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got=%h expected=none", fifo_data_out);
            end else begin
                exp_w = exp_q.pop_front();
                if (fifo_data_out !== exp_w) begin
                    failures++;
                    $display("FAIL fifo_data got=%h expected=%h", fifo_data_out, exp_w);
                end
            end
        end else if (!rst && !rst_q) begin
            checks++;
            if (fifo_data_out !== last_out) begin
                failures++;
                $display("FAIL data_hold got=%h expected=%h", fifo_data_out, last_out);
            end
        end
        if (bram_read_en && fifo_full) n_rd_full++;
        if (done) begin
            n_done++;
            last_done_cyc = cyc;
        end
        last_out = fifo_data_out;
        rst_q    = rst;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input int first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(16'h0100 + 16'(first + i));
    endtask

    task automatic pulse_start();
        drive_edge();
        start = 1'b1;
        drive_edge();
        start = 1'b0;
    endtask

    task automatic wait_wr(input string name, input int target, input int budget);
        for (int k = 0; k < budget && n_wr < target; k++) sample();
        check(name, n_wr, target);
    endtask

    task automatic wait_done(input string name, input int target, input int budget);
        for (int k = 0; k < budget && n_done < target; k++) sample();
        check(name, n_done, target);
    endtask

    int b_wr, b_clr, b_done, b_rdf;

    task automatic snap();
        b_wr = n_wr; b_clr = n_clear; b_done = n_done; b_rdf = n_rd_full;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mmcm_lock = 1'b1; fifo_full = 1'b0;
        sample();
        check("rst_busy", busy, 0);
        check("rst_strobes", {bram_read_en, fifo_write_en, fifo_clear, done}, 0);
        repeat (3) drive_edge();
        rst = 1'b0;
        sample();
        check("idle_busy", busy, 0);
        check("idle_data", fifo_data_out, 0);

        // Basic pass
        snap(); push_seq(0, 8); pulse_start();
        wait_wr("basic_writes", b_wr + 8, 40);
        wait_done("basic_done", b_done + 1, 20);
        repeat (3) sample();
        check("basic_clear_cnt", n_clear - b_clr, 1);
        check("basic_done_cnt", n_done - b_done, 1);
        check("basic_first_lat", first_wr_cyc - last_clear_cyc, 2);
        check("basic_span", last_wr_cyc - first_wr_cyc, 7);
        check("basic_done_after", int'(last_done_cyc > last_wr_cyc), 1);
        check("basic_q_empty", exp_q.size(), 0);

        // Back-pressure after the third word
        snap(); push_seq(0, 8); pulse_start();
        wait_wr("bp_three", b_wr + 3, 30);
        drive_edge();
        fifo_full = 1'b1;
        sample();
        sample();
        check("bp_skid_valid", dut.u_skid.valid, 1);
        check("bp_skid_data", dut.u_skid.data, 16'h0103);
        drive_edge();
        drive_edge();
        fifo_full = 1'b0;
        wait_wr("bp_writes", b_wr + 8, 40);
        wait_done("bp_done", b_done + 1, 20);
        check("bp_rd_while_full", n_rd_full - b_rdf, 0);
        check("bp_q_empty", exp_q.size(), 0);

        // Lock lost after the fourth word
        snap(); push_seq(0, 4); pulse_start();
        wait_wr("lock_four", b_wr + 4, 30);
        drive_edge();
        mmcm_lock = 1'b0;
        sample();
        check("lock_no_write", fifo_write_en, 0);
        sample();
        check("lock_busy", busy, 0);
        repeat (15) sample();
        check("lock_writes", n_wr - b_wr, 4);
        check("lock_no_done", n_done - b_done, 0);
        check("lock_q_empty", exp_q.size(), 0);

        // start while unlocked stays idle
        snap();
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sample();
            check("unlocked_busy", busy, 0);
        end
        check("unlocked_strobes", (n_clear - b_clr) + (n_wr - b_wr) + (n_done - b_done), 0);
        drive_edge();
        start = 1'b0;
        mmcm_lock = 1'b1;

        // Reset in DRAIN with the last word in the skid
        snap(); push_seq(0, 7); pulse_start();
        for (int k = 0; k < 30 && !(bram_read_en && bram_address_read == 3'd7); k++) sample();
        check("drain_last_read", int'(bram_address_read), 7);
        drive_edge();
        fifo_full = 1'b1;
        drive_edge();
        rst = 1'b1;
        sample();
        check("drain_skid_pre", dut.u_skid.valid, 1);
        check("drain_rst_outs", {busy, fifo_write_en, bram_read_en, fifo_clear, done}, 0);
        drive_edge();
        rst = 1'b0;
        fifo_full = 1'b0;
        sample();
        check("after_rst_outs", {busy, fifo_write_en, bram_read_en, fifo_clear, done}, 0);
        check("after_rst_data", fifo_data_out, 0);
        repeat (5) sample();
        check("drain_writes", n_wr - b_wr, 7);
        check("drain_no_done", n_done - b_done, 0);
        check("drain_q_empty", exp_q.size(), 0);
        snap(); push_seq(0, 8); pulse_start();
        wait_wr("post_rst_writes", b_wr + 8, 40);
        wait_done("post_rst_done", b_done + 1, 20);
        check("post_rst_q_empty", exp_q.size(), 0);

`ifdef STIM_FEEDER_LOOP_EN
        // Looping: 0x107 runs straight into 0x100 while start stays high
        snap(); push_seq(0, 8); push_seq(0, 8);
        drive_edge();
        start = 1'b1;
        wait_wr("loop_twelve", b_wr + 12, 60);
        drive_edge();
        start = 1'b0;
        wait_wr("loop_writes", b_wr + 16, 40);
        wait_done("loop_done", b_done + 1, 20);
        check("loop_clear_cnt", n_clear - b_clr, 1);
        check("loop_span", last_wr_cyc - first_wr_cyc, 15);
        check("loop_done_after", int'(last_done_cyc > last_wr_cyc), 1);
        check("loop_q_empty", exp_q.size(), 0);
`else
        // start held through FINISH: back-to-back passes with one idle cycle
        snap(); push_seq(0, 8); push_seq(0, 8);
        drive_edge();
        start = 1'b1;
        wait_done("b2b_first_done", b_done + 1, 60);
        for (int k = 0; k < 10 && n_clear < b_clr + 2; k++) sample();
        check("b2b_second_clear", n_clear - b_clr, 2);
        drive_edge();
        start = 1'b0;
        check("b2b_gap", last_clear_cyc - last_done_cyc, 2);
        wait_wr("b2b_writes", b_wr + 16, 60);
        wait_done("b2b_done", b_done + 2, 30);
        repeat (5) sample();
        check("b2b_done_cnt", n_done - b_done, 2);
        check("b2b_q_empty", exp_q.size(), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
